// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter and its load-tag queue.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LQ_DEPTH   = 4;

  // Source that owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

  // True when a source register is a real register (not x0) equal to a target.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] tgt);
    reg_hit = (src != {REG_ADDR_W{1'b0}}) && (src == tgt);
  endfunction

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order queue of destination registers for loads still waiting on memory.
// Every entry's tag and valid bit are exported so the parent can run
// associative hazard / WAW matches against all in-flight loads.
module ld_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [AW-1:0]       push_rd_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [AW-1:0]       head_rd_o,
  output logic [DEPTH*AW-1:0] ent_rd_o,
  output logic [DEPTH-1:0]    ent_vld_o
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    tag_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_idx_s, rd_idx_s;
  logic             do_push_s, do_pop_s;

  assign wr_idx_s  = wr_ptr_q[PW-1:0];
  assign rd_idx_s  = rd_ptr_q[PW-1:0];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx_s == rd_idx_s);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_rd_o = tag_q[rd_idx_s];
  assign ent_vld_o = vld_q;

  // Next-state for pointers and per-entry valid bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (do_pop_s) begin
      rd_ptr_d          = rd_ptr_q + {{PW{1'b0}}, 1'b1};
      vld_d[rd_idx_s]   = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s) begin
      wr_ptr_d          = wr_ptr_q + {{PW{1'b0}}, 1'b1};
      vld_d[wr_idx_s]   = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Flatten the tag storage for the parent's match logic.
  always_comb begin
    ent_rd_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_o[i*AW +: AW] = tag_q[i];
    end
  end

  // Queue state registers; reset discards every pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      if (do_push_s) begin
        tag_q[wr_idx_s] <= push_rd_i;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: in-order load returns have absolute
// priority over ALU results, ALU writes are held off while a pending load
// targets the same register, and decode is stalled on RAW hazards against
// in-flight loads and the write currently being committed.
module wb_arbiter #(
  parameter int XLEN     = wb_pkg::XLEN,
  parameter int LQ_DEPTH = wb_pkg::LQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_issue,
  input  logic [wb_pkg::REG_ADDR_W-1:0] ld_rd,
  output logic                          ld_ready,
  input  logic                          mem_valid,
  input  logic [XLEN-1:0]               mem_data,
  input  logic                          alu_valid,
  input  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  output logic                          alu_ready,
  input  logic [wb_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [wb_pkg::REG_ADDR_W-1:0] rs2,
  output logic                          hazard_stall,
  output logic                          RegWrite,
  output logic [wb_pkg::REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]               wr_data,
  output logic                          err
);

  import wb_pkg::*;

  localparam int AW = REG_ADDR_W;

  logic                   fifo_full_s, fifo_empty_s;
  logic [AW-1:0]          head_rd_s;
  logic [LQ_DEPTH*AW-1:0] ent_rd_s;
  logic [LQ_DEPTH-1:0]    ent_vld_s;
  logic                   mem_fire_s;
  logic                   alu_waw_s, rs1_ld_hit_s, rs2_ld_hit_s;
  wb_src_e                src_s;

  logic                   we_q, we_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   err_q, err_d;

  ld_tag_fifo #(
    .DEPTH (LQ_DEPTH),
    .AW    (AW)
  ) u_ld_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (ld_issue),
    .push_rd_i (ld_rd),
    .pop_i     (mem_valid),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .head_rd_o (head_rd_s),
    .ent_rd_o  (ent_rd_s),
    .ent_vld_o (ent_vld_s)
  );

  assign ld_ready   = !fifo_full_s;
  assign mem_fire_s = mem_valid && !fifo_empty_s;

  // Associative compare of ALU target and decode sources against live loads.
  always_comb begin
    alu_waw_s    = 1'b0;
    rs1_ld_hit_s = 1'b0;
    rs2_ld_hit_s = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (ent_vld_s[i]) begin
        if (ent_rd_s[i*AW +: AW] == alu_rd) alu_waw_s = 1'b1;
        if (reg_hit(rs1, ent_rd_s[i*AW +: AW])) rs1_ld_hit_s = 1'b1;
        if (reg_hit(rs2, ent_rd_s[i*AW +: AW])) rs2_ld_hit_s = 1'b1;
      end else begin
        alu_waw_s = alu_waw_s;
      end
    end
  end

  // Memory owns the write port whenever it presents data; x0 never blocks ALU.
  assign alu_ready = !mem_valid && ((alu_rd == {AW{1'b0}}) || !alu_waw_s);

  // RAW stall against queued loads and the write being committed right now.
  assign hazard_stall = rs1_ld_hit_s || rs2_ld_hit_s ||
                        (we_q && reg_hit(rs1, rd_q)) ||
                        (we_q && reg_hit(rs2, rd_q));

  // Pick the writeback source and form the next writeback register contents.
  always_comb begin
    src_s  = WB_NONE;
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (mem_fire_s) begin
      src_s = WB_MEM;
    end else if (alu_valid && alu_ready) begin
      src_s = WB_ALU;
    end else begin
      src_s = WB_NONE;
    end
    case (src_s)
      WB_MEM: begin
        rd_d   = head_rd_s;
        data_d = mem_data;
        we_d   = (head_rd_s != {AW{1'b0}});
      end
      WB_ALU: begin
        rd_d   = alu_rd;
        data_d = alu_data;
        we_d   = (alu_rd != {AW{1'b0}});
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Sticky protocol error: queue overflow or a data return with nothing pending.
  always_comb begin
    err_d = err_q;
    if ((ld_issue && fifo_full_s) || (mem_valid && fifo_empty_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // One-cycle writeback register and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign RegWrite = we_q;
  assign rd       = rd_q;
  assign wr_data  = data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model predicts handshakes
// and stall each cycle, queues the expected writeback, and compares it one
// cycle later against the registered outputs.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_issue, mem_valid, alu_valid;
  logic [4:0]  ld_rd, alu_rd, rs1, rs2;
  logic [31:0] mem_data, alu_data;
  logic        ld_ready, alu_ready, hazard_stall, RegWrite, err;
  logic [4:0]  rd;
  logic [31:0] wr_data;

  typedef struct {
    logic        has;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t    sb[$];
  logic [4:0] mq[$];
  logic       m_we, m_err;
  logic [4:0] m_rd;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .LQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .rs1(rs1), .rs2(rs2), .hazard_stall(hazard_stall),
    .RegWrite(RegWrite), .rd(rd), .wr_data(wr_data), .err(err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_q(input logic [4:0] r);
    in_q = 1'b0;
    foreach (mq[i]) if (mq[i] == r) in_q = 1'b1;
  endfunction

  function automatic logic m_hz(input logic [4:0] r);
    m_hz = (r != 5'd0) && (in_q(r) || (m_we && (m_rd == r)));
  endfunction

  task automatic idle();
    ld_issue = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    ld_rd = 5'd0; alu_rd = 5'd0; mem_data = 32'd0; alu_data = 32'd0;
  endtask

  // One clock: predict at the falling edge, compare writeback after the rise.
  task automatic step();
    wb_exp_t    e;
    logic       full, empty, exp_ar;
    logic [4:0] tmp;
    @(negedge clk);
    full   = (mq.size() == 4);
    empty  = (mq.size() == 0);
    exp_ar = !mem_valid && ((alu_rd == 5'd0) || !in_q(alu_rd));
    check_eq("ld_ready", ld_ready, !full);
    check_eq("alu_ready", alu_ready, exp_ar);
    check_eq("hazard_stall", hazard_stall, m_hz(rs1) || m_hz(rs2));
    e.has = 1'b0; e.rd = 5'd0; e.data = 32'd0;
    if (mem_valid && !empty) begin
      e.has = 1'b1; e.rd = mq[0]; e.data = mem_data;
    end else if (alu_valid && exp_ar) begin
      e.has = 1'b1; e.rd = alu_rd; e.data = alu_data;
    end
    e.we = e.has && (e.rd != 5'd0);
    sb.push_back(e);
    if ((mem_valid && empty) || (ld_issue && full)) m_err = 1'b1;
    if (mem_valid && !empty) tmp = mq.pop_front();
    if (ld_issue && !full) mq.push_back(ld_rd);
    if (e.has) m_rd = e.rd;
    m_we = e.we;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_eq("RegWrite", RegWrite, e.we);
      if (e.has) begin
        check_eq("rd", rd, e.rd);
        check_eq("wr_data", wr_data, e.data);
      end
    end
    check_eq("err", err, m_err);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete(); m_we = 1'b0; m_rd = 5'd0; m_err = 1'b0;
    check_eq("rst_ld_ready", ld_ready, 1'b1);
    check_eq("rst_hazard", hazard_stall, 1'b0);
    check_eq("rst_RegWrite", RegWrite, 1'b0);
    check_eq("rst_rd", rd, 5'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_err", err, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); ld_issue = 1'b1; ld_rd = r; step();
  endtask

  task automatic ret(input logic [31:0] d);
    idle(); mem_valid = 1'b1; mem_data = d; step();
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    idle();
    m_we = 1'b0; m_rd = 5'd0; m_err = 1'b0;
    #2;
    do_reset();

    // ALU only
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check_eq("alu_only_ready", alu_ready, 1'b1);
    step();
    check_eq("alu_only_we", RegWrite, 1'b1);
    check_eq("alu_only_data", wr_data, 32'hDEADBEEF);

    // Load ordering with rs1 watching x7
    rs1 = 5'd7;
    issue(5'd3);
    issue(5'd7);
    idle(); step();
    ret(32'h11);
    check_eq("ord_rd0", rd, 5'd3);
    ret(32'h22);
    check_eq("ord_rd1", rd, 5'd7);
    check_eq("ord_stall_wr", hazard_stall, 1'b1);
    idle(); step();
    check_eq("ord_stall_clear", hazard_stall, 1'b0);
    rs1 = 5'd0;

    // Collision: memory wins, ALU lands one cycle later
    issue(5'd4);
    idle(); mem_valid = 1'b1; mem_data = 32'h33;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    step();
    check_eq("col_mem_rd", rd, 5'd4);
    mem_valid = 1'b0;
    step();
    check_eq("col_alu_rd", rd, 5'd6);

    // WAW guard on a pending load to x3
    issue(5'd3);
    idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
    step(); step();
    mem_valid = 1'b1; mem_data = 32'h44;
    step();
    mem_valid = 1'b0;
    step();
    check_eq("waw_alu_data", wr_data, 32'hA3);

    // Empty return is an error with no write
    ret(32'h55);
    check_eq("empty_pop_err", err, 1'b1);
    check_eq("empty_pop_we", RegWrite, 1'b0);
    do_reset();

    // Fill, overflow
    issue(5'd1); issue(5'd2); issue(5'd8); issue(5'd9);
    check_eq("fill_ld_ready", ld_ready, 1'b0);
    issue(5'd10);
    check_eq("ovf_err", err, 1'b1);
    ret(32'h1); ret(32'h2); ret(32'h8); ret(32'h9);
    do_reset();

    // Push and pop together at occupancy 2
    issue(5'd11); issue(5'd12);
    idle(); ld_issue = 1'b1; ld_rd = 5'd13; mem_valid = 1'b1; mem_data = 32'hB;
    step();
    issue(5'd14);
    check_eq("occ3_ld_ready", ld_ready, 1'b1);
    issue(5'd15);
    check_eq("occ4_ld_ready", ld_ready, 1'b0);
    // Push and pop together while full: push dropped, flagged
    idle(); ld_issue = 1'b1; ld_rd = 5'd16; mem_valid = 1'b1; mem_data = 32'hC;
    step();
    ret(32'hD); ret(32'hE); ret(32'hF);

    // x0 writes suppressed
    idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    step();
    check_eq("x0_we", RegWrite, 1'b0);
    do_reset();

    // Reset with 3 loads pending and a write in flight
    issue(5'd20); issue(5'd21); issue(5'd22);
    idle(); alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    rs1 = 5'd21;
    #1 check_eq("pre_rst_hazard", hazard_stall, 1'b1);
    check_eq("pre_rst_we", RegWrite, 1'b1);
    do_reset();
    rs1 = 5'd0;
    ret(32'hE0);
    check_eq("post_rst_pop_err", err, 1'b1);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      ld_issue  = ($urandom_range(0, 2) == 0);
      ld_rd     = 5'($urandom_range(0, 9));
      mem_valid = (mq.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mem_data  = $urandom;
      alu_valid = ($urandom_range(0, 1) == 0);
      alu_rd    = 5'($urandom_range(0, 9));
      alu_data  = $urandom;
      rs1       = 5'($urandom_range(0, 9));
      rs2       = 5'($urandom_range(0, 9));
      step();
      if (n % 100 == 99) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
